fu_broadcast_queue: RTL and testbench

Receiving end of the functional-unit completion interface. It captures each finished result and its execution tag from one functional unit, acknowledges with a one-cycle `queued` pulse so the FU can return to idle, and buffers entries in a FIFO. Entries drain in order to the common data bus (CDB) under a valid/grant handshake from the CDB arbiter. One instance sits behind each FU.

---
 rtl/core_pkg.sv | 10 +
 rtl/sync_fifo_mem.sv | 18 +
 rtl/fu_broadcast_queue.sv | 70 +++++++
 tb/tb_fu_broadcast_queue.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared result-bus widths and the CDB entry record used by the FU
// queues, the CDB arbiter and the reservation stations.
package core_pkg;
   localparam int CORE_DATA_WIDTH = 32;
   localparam int CORE_TAG_WIDTH  = 7;
   typedef struct packed {
      logic [CORE_DATA_WIDTH-1:0] data;
      logic [CORE_TAG_WIDTH-1:0]  tag;
   } cdb_entry_t;
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH x WIDTH register array with one clocked write port and
// one combinational read port; contents are never reset.
module sync_fifo_mem #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 39
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [WIDTH-1:0]         o_rdata
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   always_ff @(posedge clk)
      if (i_we) r_mem[i_waddr] <= i_wdata;
   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fu_broadcast_queue.sv
// fu_broadcast_queue: captures FU completions into a FIFO, acknowledges each
// with a one-cycle queued pulse, and drains in order to the CDB on grant.
module fu_broadcast_queue
   import core_pkg::*;
#(
   parameter int DATA_WIDTH = CORE_DATA_WIDTH,
   parameter int TAG_WIDTH  = CORE_TAG_WIDTH,
   parameter int DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       fu_done,
   input  logic [DATA_WIDTH-1:0]      fu_result,
   input  logic [TAG_WIDTH-1:0]       fu_tag,
   output logic                       queued,
   output logic                       cdb_valid,
   output logic [DATA_WIDTH-1:0]      cdb_data,
   output logic [TAG_WIDTH-1:0]       cdb_tag,
   input  logic                       cdb_grant,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int W  = DATA_WIDTH + TAG_WIDTH;

   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_pending, r_queued;
   logic          w_req, w_pop, w_wr, w_valid;
   logic [W-1:0]  w_rdata;

   assign w_valid = r_count != '0;
   assign w_req   = fu_done | r_pending;
   assign w_pop   = cdb_grant & w_valid;
   // a pop frees a slot on the same edge, so a full queue still accepts a write
   assign w_wr    = w_req & ((r_count < CW'(DEPTH)) | w_pop);

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_pending <= 1'b0;
         r_queued  <= 1'b0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count   <= r_count + CW'(w_wr) - CW'(w_pop);
         r_pending <= w_wr ? 1'b0 : (w_req ? 1'b1 : r_pending);
         r_queued  <= w_wr;
      end

   sync_fifo_mem #(.DEPTH(DEPTH), .WIDTH(W)) u_mem (
      .clk     (clk),
      .i_we    (w_wr),
      .i_waddr (r_wr_ptr),
      .i_wdata ({fu_result, fu_tag}),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );

   assign queued    = r_queued;
   assign cdb_valid = w_valid;
   assign cdb_data  = w_rdata[W-1:TAG_WIDTH];
   assign cdb_tag   = w_rdata[TAG_WIDTH-1:0];
   assign count     = r_count;

   // the FU may not complete again while its previous result awaits capture
   a_no_redispatch: assert property (@(posedge clk) disable iff (!rst) fu_done |-> !r_pending);
endmodule

// File: tb/tb_fu_broadcast_queue.sv
// tb_fu_broadcast_queue: table-driven directed vectors plus hand sequences for
// full stall, push/pop at full, grant while empty and mid-operation reset.
module tb_fu_broadcast_queue;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fu_done = 1'b0;
   logic [31:0] fu_result = '0;
   logic [6:0]  fu_tag = '0;
   logic        cdb_grant = 1'b0;
   logic        queued, cdb_valid;
   logic [31:0] cdb_data;
   logic [6:0]  cdb_tag;
   logic [2:0]  count;
   int          n_chk = 0;
   int          n_fail = 0;

   typedef struct {
      logic        done;
      logic [31:0] res;
      logic [6:0]  tag;
      logic        grant;
      logic        q;
      logic        v;
      logic [31:0] d;
      logic [6:0]  t;
      logic [2:0]  c;
   } vec_t;
   vec_t tbl [16];

   always #5 clk = ~clk;

   fu_broadcast_queue dut (
      .clk       (clk),
      .rst       (rst_n),
      .fu_done   (fu_done),
      .fu_result (fu_result),
      .fu_tag    (fu_tag),
      .queued    (queued),
      .cdb_valid (cdb_valid),
      .cdb_data  (cdb_data),
      .cdb_tag   (cdb_tag),
      .cdb_grant (cdb_grant),
      .count     (count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [6:0] t, input logic [31:0] d);
      fu_done = 1'b1; fu_tag = t; fu_result = d;
      step();
      chk("push_queued", queued, 1'b1);
      fu_done = 1'b0;
      step();
      chk("push_queued_drop", queued, 1'b0);
   endtask

   task automatic pop_expect(input logic [6:0] t, input logic [31:0] d);
      chk("pop_valid", cdb_valid, 1'b1);
      chk("pop_tag", cdb_tag, t);
      chk("pop_data", cdb_data, d);
      cdb_grant = 1'b1;
      step();
      cdb_grant = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{1, 32'hFF, 7'h05, 0, 1, 1, 32'hFF, 7'h05, 1};
      tbl[1]  = '{0, 32'hFF, 7'h05, 0, 0, 1, 32'hFF, 7'h05, 1};
      tbl[2]  = '{0, 32'hFF, 7'h05, 1, 0, 0, 32'h0,  7'h0,  0};
      tbl[3]  = '{0, 32'hFF, 7'h05, 1, 0, 0, 32'h0,  7'h0,  0};
      tbl[4]  = '{1, 32'h11, 7'h01, 0, 1, 1, 32'h11, 7'h01, 1};
      tbl[5]  = '{0, 32'h11, 7'h01, 0, 0, 1, 32'h11, 7'h01, 1};
      tbl[6]  = '{1, 32'h22, 7'h02, 0, 1, 1, 32'h11, 7'h01, 2};
      tbl[7]  = '{0, 32'h22, 7'h02, 0, 0, 1, 32'h11, 7'h01, 2};
      tbl[8]  = '{1, 32'h33, 7'h03, 0, 1, 1, 32'h11, 7'h01, 3};
      tbl[9]  = '{0, 32'h33, 7'h03, 0, 0, 1, 32'h11, 7'h01, 3};
      tbl[10] = '{1, 32'h44, 7'h04, 0, 1, 1, 32'h11, 7'h01, 4};
      tbl[11] = '{0, 32'h44, 7'h04, 0, 0, 1, 32'h11, 7'h01, 4};
      tbl[12] = '{0, 32'h44, 7'h04, 1, 0, 1, 32'h22, 7'h02, 3};
      tbl[13] = '{0, 32'h44, 7'h04, 1, 0, 1, 32'h33, 7'h03, 2};
      tbl[14] = '{0, 32'h44, 7'h04, 1, 0, 1, 32'h44, 7'h04, 1};
      tbl[15] = '{0, 32'h44, 7'h04, 1, 0, 0, 32'h0,  7'h0,  0};

      #2;
      chk("rst_queued", queued, 1'b0);
      chk("rst_valid", cdb_valid, 1'b0);
      chk("rst_count", count, 3'd0);
      step();
      rst_n = 1'b1;
      #2;

      for (int i = 0; i < 16; i++) begin
         fu_done = tbl[i].done; fu_result = tbl[i].res; fu_tag = tbl[i].tag; cdb_grant = tbl[i].grant;
         step();
         chk($sformatf("v%0d_queued", i), queued, tbl[i].q);
         chk($sformatf("v%0d_valid", i), cdb_valid, tbl[i].v);
         chk($sformatf("v%0d_count", i), count, tbl[i].c);
         if (tbl[i].v) begin
            chk($sformatf("v%0d_data", i), cdb_data, tbl[i].d);
            chk($sformatf("v%0d_tag", i), cdb_tag, tbl[i].t);
         end
      end
      fu_done = 1'b0; cdb_grant = 1'b0;

      // full stall, then release through a grant
      push(7'h21, 32'hA1);
      push(7'h22, 32'hA2);
      push(7'h23, 32'hA3);
      push(7'h24, 32'hA4);
      chk("full_count", count, 3'd4);
      fu_done = 1'b1; fu_tag = 7'h09; fu_result = 32'h99;
      for (int k = 0; k < 3; k++) begin
         step();
         fu_done = 1'b0;
         chk("stall_queued", queued, 1'b0);
         chk("stall_pending", dut.r_pending, 1'b1);
         chk("stall_count", count, 3'd4);
         chk("stall_head", cdb_tag, 7'h21);
      end
      cdb_grant = 1'b1;
      step();
      cdb_grant = 1'b0;
      chk("release_queued", queued, 1'b1);
      chk("release_count", count, 3'd4);
      chk("release_head", cdb_tag, 7'h22);
      chk("release_pending", dut.r_pending, 1'b0);
      step();
      chk("release_queued_drop", queued, 1'b0);

      // simultaneous push and pop at full
      fu_done = 1'b1; fu_tag = 7'h0A; fu_result = 32'hAA; cdb_grant = 1'b1;
      step();
      fu_done = 1'b0; cdb_grant = 1'b0;
      chk("pp_queued", queued, 1'b1);
      chk("pp_count", count, 3'd4);
      step();
      pop_expect(7'h23, 32'hA3);
      pop_expect(7'h24, 32'hA4);
      pop_expect(7'h09, 32'h99);
      pop_expect(7'h0A, 32'hAA);
      chk("drain_count", count, 3'd0);
      chk("drain_valid", cdb_valid, 1'b0);

      // grant while empty leaves pointers alone
      cdb_grant = 1'b1;
      step();
      step();
      cdb_grant = 1'b0;
      chk("empty_grant_count", count, 3'd0);
      chk("empty_grant_valid", cdb_valid, 1'b0);
      push(7'h31, 32'hB1);
      pop_expect(7'h31, 32'hB1);

      // mid-operation reset with a full queue and a pending capture
      push(7'h41, 32'hC1);
      push(7'h42, 32'hC2);
      push(7'h43, 32'hC3);
      push(7'h44, 32'hC4);
      fu_done = 1'b1; fu_tag = 7'h45; fu_result = 32'hC5;
      step();
      fu_done = 1'b0;
      chk("pre_rst_pending", dut.r_pending, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", cdb_valid, 1'b0);
      chk("mid_rst_queued", queued, 1'b0);
      chk("mid_rst_count", count, 3'd0);
      chk("mid_rst_pending", dut.r_pending, 1'b0);
      step();
      rst_n = 1'b1;
      #2;
      fu_done = 1'b1; fu_tag = 7'h7F; fu_result = 32'h7F7F;
      step();
      fu_done = 1'b0;
      chk("post_rst_queued", queued, 1'b1);
      chk("post_rst_count", count, 3'd1);
      step();
      pop_expect(7'h7F, 32'h7F7F);
      chk("post_rst_empty", count, 3'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
